// File: rtl/adc_acq_multi.sv
// adc_acq_multi: multi-channel ADC acquisition block.
// Tagged samples are averaged in groups of 2^AVG_LOG2 per channel. Each
// channel has one result register. A control/status word and all results
// are presented on a 32-bit readout mux.
// Optional feature: define ACQ_THRESH_EN to compare every completed
// average against THRESH and raise a sticky ALARM that also drives irq.
module adc_acq_multi #(
    parameter int                N_CH     = 4,
    parameter int                DATA_W   = 12,
    parameter int                AVG_LOG2 = 2,
    parameter logic [DATA_W-1:0] THRESH   = DATA_W'(12'hC00)
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              WR1C,
    input  logic [8:0]        i_ext,
    input  logic              adc_valid,
    input  logic [2:0]        adc_chan,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [3:0]        sel_mux,
    input  logic              rd_en,
    output logic [31:0]       out,
    output logic              irq
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

`ifdef ACQ_THRESH_EN
    localparam bit ALARM_EN = 1'b1;
`else
    // Constant-false gate: the comparator folds away and ALARM stays 0.
    localparam bit ALARM_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Stored part of the control word; CLR is an action, never stored.
    typedef struct packed {
        logic [4:0] user;
        logic       irq_en;
        logic       cont;
        logic       en;
    } ctrl_t;

    state_t            state_q, state_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [ACC_W-1:0]  acc_q  [N_CH];
    logic [ACC_W-1:0]  acc_d  [N_CH];
    logic [CNT_W-1:0]  cnt_q  [N_CH];
    logic [CNT_W-1:0]  cnt_d  [N_CH];
    logic [DATA_W-1:0] data_q [N_CH];
    logic [DATA_W-1:0] data_d [N_CH];
    logic [N_CH-1:0]   new_q, new_d;
    logic [N_CH-1:0]   done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              alarm_q, alarm_d;
    logic              irq_q, irq_d;

    logic              samp_ok;
    logic [N_CH-1:0]   hit;
    logic [N_CH-1:0]   res_fire;
    logic [N_CH-1:0]   over_thresh;
    logic [ACC_W-1:0]  sum [N_CH];
    logic [DATA_W-1:0] avg [N_CH];
    logic              enter_run;
    logic              wr_clr;
    logic [31:0]       status;

    // Sample decode: which channel takes the sample and whether it completes an average.
    always_comb begin
        samp_ok = adc_valid && (state_q == S_RUN);
        for (int k = 0; k < N_CH; k++) begin
            hit[k]         = samp_ok && (adc_chan == 3'(k));
            sum[k]         = acc_q[k] + ACC_W'(adc_data);
            avg[k]         = DATA_W'(sum[k] >> AVG_LOG2);
            res_fire[k]    = hit[k] && (cnt_q[k] == CNT_LAST);
            over_thresh[k] = ALARM_EN && (avg[k] > THRESH);
        end
    end

    // Control FSM next state; a control write overrides the single-shot completion.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        ctrl_d  = ctrl_q;
        case (state_q)
            S_IDLE: if (ctrl_q.en) state_d = S_RUN;
            S_RUN: begin
                if (!ctrl_q.cont && (&(done_q | res_fire))) begin
                    state_d   = S_DONE;
                    ctrl_d.en = 1'b0;
                end
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (WR1C) begin
            ctrl_d.en     = i_ext[0];
            ctrl_d.cont   = i_ext[1];
            ctrl_d.irq_en = i_ext[3];
            ctrl_d.user   = i_ext[8:4];
            state_d       = i_ext[0] ? S_RUN : S_IDLE;
        end
    end

    assign enter_run = (state_d == S_RUN) && (state_q != S_RUN);
    assign wr_clr    = WR1C && i_ext[2];

    // Accumulators, results and flags; clears are applied first so a new result wins.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        new_d   = new_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        alarm_d = alarm_q;
        if (wr_clr) begin
            new_d   = '0;
            ovf_d   = 1'b0;
            alarm_d = 1'b0;
        end
        for (int k = 0; k < N_CH; k++) begin
            if (rd_en && (sel_mux == 4'(k + 1))) new_d[k] = 1'b0;
            if (hit[k]) begin
                if (res_fire[k]) begin
                    data_d[k] = avg[k];
                    new_d[k]  = 1'b1;
                    done_d[k] = 1'b1;
                    acc_d[k]  = '0;
                    cnt_d[k]  = '0;
                    if (new_q[k])       ovf_d   = 1'b1;
                    if (over_thresh[k]) alarm_d = 1'b1;
                end else begin
                    acc_d[k] = sum[k];
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
        // A fresh run starts from empty accumulators and an empty completion mask.
        if (enter_run) begin
            for (int k = 0; k < N_CH; k++) begin
                acc_d[k] = '0;
                cnt_d[k] = '0;
            end
            done_d = '0;
        end
    end

    assign irq_d = ctrl_q.irq_en & ((|new_q) | alarm_q);

    // Status word assembly and readout mux.
    always_comb begin
        status              = '0;
        status[0]           = ctrl_q.en;
        status[1]           = ctrl_q.cont;
        status[3]           = ctrl_q.irq_en;
        status[8:4]         = ctrl_q.user;
        status[16]          = (state_q == S_RUN);
        status[17]          = |new_q;
        status[18]          = ovf_q;
        status[19]          = alarm_q;
        status[24 +: N_CH]  = new_q;
        out = '0;
        if (sel_mux == 4'd0) out = status;
        for (int k = 0; k < N_CH; k++) begin
            if (sel_mux == 4'(k + 1)) out = 32'(data_q[k]);
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
            // NOTE: the result array is reset because a readout straight after reset must return 0.
            acc_q   <= '{default: '0};
            cnt_q   <= '{default: '0};
            data_q  <= '{default: '0};
            new_q   <= '0;
            done_q  <= '0;
            ovf_q   <= 1'b0;
            alarm_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            new_q   <= new_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            alarm_q <= alarm_d;
            irq_q   <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: doc/adc_acq_multi.md
# adc_acq_multi

Parametrised multi-channel acquisition block: accepts tagged ADC samples, averages 2^AVG_LOG2 samples per channel, holds one result register per channel plus a control/status register, and presents any of them on a 32-bit readout port. It replaces the single-channel data-register/control-register/control-FSM/mux arrangement. It sits between the XADC wrapper and the bus/readout logic.

## Interface
- N_CH, 4: number of channels, 1..8.
- DATA_W, 12: ADC sample width, 1..16.
- AVG_LOG2, 2: log2 of the samples averaged per result, 0..4.
- THRESH, 12'hC00: alarm threshold, DATA_W bits. Used only with ACQ_THRESH_EN.
- clk_in  input  1  sole clock; all logic samples on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- WR1C  input  1  control write strobe; loads i_ext.
- i_ext  input  9  control word: [0] EN, [1] CONT, [2] CLR (self-clearing), [3] IRQ_EN, [8:4] USER (stored only).
- adc_valid  input  1  sample strobe.
- adc_chan  input  3  sample channel tag.
- adc_data  input  DATA_W  sample value, unsigned.
- sel_mux  input  4  readout select: 0 = control/status, k = data of channel k-1 (1..N_CH); other values read 0.
- rd_en  input  1  read-acknowledge for the selected data register.
- out  output  32  readout (combinational from registers).
- irq  output  1  registered interrupt.

## Operation
- Status word: [0] EN, [1] CONT, [3] IRQ_EN, [8:4] USER, [16] BUSY (state RUN), [17] ANY_NEW, [18] OVF, [19] ALARM, [24+k] NEW[k]; other bits 0.
- FSM states IDLE, RUN, DONE.
  - IDLE -> RUN when EN=1 in the register.
  - RUN -> DONE in single-shot (CONT=0) once every channel has produced a result since entering RUN; EN clears on that transition.
  - DONE -> RUN on the next EN=1 write.
  - Any write with EN=0 -> IDLE.
- Entering RUN clears all accumulators, counters and the per-run completion mask.
- In RUN, each adc_valid with adc_chan < N_CH adds adc_data to acc[chan] (DATA_W+AVG_LOG2 bits, no overflow possible) and increments cnt[chan].
  - When that sample is sample number 2^AVG_LOG2, data[chan] <= (acc + sample) >> AVG_LOG2, NEW[chan] sets, and acc/cnt clear.
  - Data is zero-extended to 32 bits on out.
- Samples with adc_chan >= N_CH, or samples arriving outside RUN, are ignored.
- Result on a channel whose NEW is still set: OVF sets (sticky) and data is overwritten.
- rd_en with sel_mux = k clears NEW[k-1]. If a new result lands on the same channel in the same cycle, the set wins.
- CLR=1 write clears OVF, ALARM and all NEW. CLR is not stored.
- irq <= IRQ_EN & (ANY_NEW | ALARM).
- WR1C coincident with adc_valid: the sample is processed under the old configuration, and the new configuration applies from the next cycle.

## Timing
- Reset (rst=0 at an edge): state IDLE, control register 0, all data/acc/cnt 0, all flags 0, irq 0, out 0 (sel 0).
- Control write visible on out (sel 0) one cycle after the WR1C edge. RUN begins that same cycle.
- Final sample at edge t: data, NEW, OVF and ALARM are valid after edge t. irq rises after edge t+1.
- Single-shot DONE and EN clear occur at the same edge as the last channel's result.
- rst asserted mid-accumulation discards partial sums. No result is emitted.
- Throughput: one sample per cycle, any channel interleave.

## Configuration
- ACQ_THRESH_EN defined: each completed average is compared against THRESH. Result > THRESH sets ALARM (sticky until CLR), and ALARM contributes to irq.
- Not defined: no comparator is built, status bit 19 reads 0, and irq depends only on ANY_NEW.

## Test plan
- Reset then idle: rst=0 for 2 cycles -> out=0, irq=0 for sel 0..N_CH. Write i_ext=9'h001 -> status reads 0x0001_0001 (EN, BUSY).
- Averaging, defaults: chan 0 samples 100,200,300,400 -> data0=250, NEW[0]=1 one edge after the 4th sample, out(sel=1)=250.
- Overrun and read-clear: two full averages on chan 2 without rd_en -> OVF=1. rd_en with sel=3 -> NEW[2]=0 next cycle. rd_en coincident with a new result -> NEW[2] stays 1.
- Single-shot: i_ext=0x001, N_CH=4, interleaved samples on chans 0..3 -> state DONE, EN=0, BUSY=0 at the edge of the last result. Further samples are ignored.
- Interrupt and threshold (ACQ_THRESH_EN): i_ext=0x009, four samples of 4000 on chan 1 -> ALARM=1, irq=1 two edges after the 4th sample. CLR write 0x00D -> ALARM=0 and irq=0 the following cycle.
- Edge cases: adc_chan=5 with N_CH=4 is ignored. rst=0 after 2 of 4 samples, then a restart -> first result equals the average of the new samples only.
